// File: rtl/mole_hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mole_hit_judge
// Description : Player-side judge for the whack-a-mole game. Latches each
//               displayed mole (position and type), debounces the four whack
//               buttons, judges the first press against the armed mole, and
//               keeps the BCD score, lives left and miss count. Flags a
//               sticky game over when the lives run out.
// Ports       : clk            - system clock, rising edge
//               restart_n      - asynchronous active-low reset
//               new_mole       - 1-cycle strobe, latch anode_en_mole/type_of_mole
//               anode_en_mole  - active-low one-hot mole position
//               type_of_mole   - 0 plague, 1 normal, 2 golden, 3 empty, else idle
//               btn            - raw active-high whack buttons
//               score_bcd      - {tens,ones} BCD score, saturates at 99
//               lives          - remaining lives
//               misses         - binary miss count, saturates at 255
//               hit_pulse      - 1-cycle pulse on a scoring hit
//               miss_pulse     - 1-cycle pulse on a miss or plague hit
//               game_over      - sticky once lives reach 0
// Revision    : 1.0 - initial release
// ============================================================================
module mole_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WINDOW_CYCLES   = 50000000,
  parameter int START_LIVES     = 3
) (
  input  logic       clk,
  input  logic       restart_n,
  input  logic       new_mole,
  input  logic [3:0] anode_en_mole,
  input  logic [2:0] type_of_mole,
  input  logic [3:0] btn,
  output logic [7:0] score_bcd,
  output logic [2:0] lives,
  output logic [7:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_tmr_w = $clog2(WINDOW_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // BCD helpers: +n with saturation at 99, and -1 with floor at 00
  // --------------------------------------------------------------------------
  function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [1:0] n);
    logic [4:0] sum;
    logic [7:0] res;
    sum = {1'b0, s[3:0]} + {3'b000, n};
    if (sum > 5'd9) begin
      if (s[7:4] == 4'd9) res = 8'h99;
      else                res = {s[7:4] + 4'd1, 4'(sum - 5'd10)};
    end else begin
      res = {s[7:4], sum[3:0]};
    end
    return res;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    logic [7:0] res;
    if (s[3:0] != 4'd0)      res = {s[7:4], s[3:0] - 4'd1};
    else if (s[7:4] != 4'd0) res = {s[7:4] - 4'd1, 4'd9};
    else                     res = 8'h00;
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Per-button synchronizer, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  logic [3:0] w_press;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              level_prev_q;
    logic [c_db_w-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive disagreeing samples already seen; the level
    // flips on the DEBOUNCE_CYCLES-th one and any agreement restarts the count.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == c_db_w'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
        else                                       cnt_d   = cnt_q + c_db_w'(1);
      end
    end

    always_ff @(posedge clk or negedge restart_n) begin
      if (!restart_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn[gi];
        sync2_q      <= sync1_q;
        level_q      <= level_d;
        level_prev_q <= level_q;
        cnt_q        <= cnt_d;
      end
    end

    assign w_press[gi] = level_q & ~level_prev_q;
  end

  // --------------------------------------------------------------------------
  // Judge state machine and game counters
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [3:0]         pos_q, pos_d;      // active-high position mask of the mole
  logic [2:0]         kind_q, kind_d;
  logic [c_tmr_w-1:0] timer_q, timer_d;
  logic [7:0]         score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [7:0]         misses_q, misses_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               over_q, over_d;

  logic w_latch, w_add1, w_add2, w_penalty, w_miss_cnt, w_lose;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    kind_d     = kind_q;
    timer_d    = timer_q;
    score_d    = score_q;
    lives_d    = lives_q;
    misses_d   = misses_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    over_d     = over_q;
    w_latch    = 1'b0;
    w_add1     = 1'b0;
    w_add2     = 1'b0;
    w_penalty  = 1'b0;
    w_miss_cnt = 1'b0;
    w_lose     = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (new_mole) w_latch = 1'b1;
      end
      ST_ARMED: begin
        // A fresh mole overrides a press in the same cycle; a press in the
        // same cycle as the window expiry is judged and the expiry dropped.
        if (new_mole) begin
          w_latch = 1'b1;
        end else if (|w_press) begin
          state_d = ST_LOCKED;
          if ($onehot(w_press) && (w_press == pos_q)) begin
            case (kind_q)
              3'd1:    w_add1 = 1'b1;
              3'd2:    w_add2 = 1'b1;
              3'd0:    w_lose = 1'b1;
              default: begin
                w_penalty  = 1'b1;
                w_miss_cnt = 1'b1;
              end
            endcase
          end else begin
            w_penalty  = 1'b1;
            w_miss_cnt = 1'b1;
          end
        end else if (timer_q == c_tmr_w'(WINDOW_CYCLES - 1)) begin
          state_d = ST_LOCKED;
          if ((kind_q == 3'd1) || (kind_q == 3'd2)) begin
            w_lose     = 1'b1;
            w_miss_cnt = 1'b1;
          end
        end else begin
          timer_d = timer_q + c_tmr_w'(1);
        end
      end
      default: begin
        // ST_OVER: frozen until reset
      end
    endcase

    if (w_latch) begin
      pos_d   = ~anode_en_mole;
      kind_d  = type_of_mole;
      timer_d = '0;
      state_d = ST_ARMED;
    end
    if (w_add1) begin
      score_d = bcd_add(score_q, 2'd1);
      hit_d   = 1'b1;
    end
    if (w_add2) begin
      score_d = bcd_add(score_q, 2'd2);
      hit_d   = 1'b1;
    end
    if (w_penalty) score_d = bcd_dec(score_q);
    if (w_miss_cnt) begin
      miss_d = 1'b1;
      if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
    end
    if (w_lose) begin
      miss_d = 1'b1;
      if (lives_q <= 3'd1) begin
        lives_d = 3'd0;
        state_d = ST_OVER;
        over_d  = 1'b1;
      end else begin
        lives_d = lives_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_q  <= ST_IDLE;
      pos_q    <= 4'd0;
      kind_q   <= 3'd0;
      timer_q  <= '0;
      score_q  <= 8'h00;
      lives_q  <= 3'(START_LIVES);
      misses_q <= 8'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      kind_q   <= kind_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
    end
  end

  assign score_bcd  = score_q;
  assign lives      = lives_q;
  assign misses     = misses_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign game_over  = over_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mole_hit_judge
// Description : Self-checking bench for mole_hit_judge. Stimulus tasks push
//               the expected judgement (cycle, pulses, counters) into a
//               queue; a monitor pops and compares whenever the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_hit_judge;

  localparam int DB = 4;
  localparam int W  = 20;
  localparam int L  = 3;

  logic       clk       = 1'b0;
  logic       restart_n = 1'b0;
  logic       new_mole  = 1'b0;
  logic [3:0] anode     = 4'hF;
  logic [2:0] mtype     = 3'd3;
  logic [3:0] btn       = 4'd0;
  logic [7:0] score_bcd;
  logic [2:0] lives;
  logic [7:0] misses;
  logic       hit_pulse, miss_pulse, game_over;

  mole_hit_judge #(
    .DEBOUNCE_CYCLES(DB),
    .WINDOW_CYCLES  (W),
    .START_LIVES    (L)
  ) dut (
    .clk          (clk),
    .restart_n    (restart_n),
    .new_mole     (new_mole),
    .anode_en_mole(anode),
    .type_of_mole (mtype),
    .btn          (btn),
    .score_bcd    (score_bcd),
    .lives        (lives),
    .misses       (misses),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit hit;
    bit miss;
    int score;
    int lives;
    int misses;
    bit over;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference game state as plain integers
  int m_score, m_lives, m_misses;
  bit m_over;

  function automatic int to_bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_score  = 0;
    m_lives  = L;
    m_misses = 0;
    m_over   = 1'b0;
    sbq.delete();
  endtask

  task automatic push_ev(input int c, input bit h, input bit m);
    exp_t e;
    e.cyc = c; e.hit = h; e.miss = m;
    e.score = m_score; e.lives = m_lives; e.misses = m_misses; e.over = m_over;
    sbq.push_back(e);
  endtask

  task automatic lose_life();
    m_lives = m_lives - 1;
    if (m_lives == 0) m_over = 1'b1;
  endtask

  task automatic count_miss();
    if (m_misses < 255) m_misses++;
  endtask

  // Judgement of a press on an armed mole, as the game rules describe it
  task automatic model_press(input int pos, input int typ, input logic [3:0] mask, input int jc);
    logic [3:0] want;
    if (m_over) return;
    want = 4'(1 << pos);
    if ($countones(mask) == 1 && mask == want && typ == 1) begin
      m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
      push_ev(jc, 1'b1, 1'b0);
    end else if ($countones(mask) == 1 && mask == want && typ == 2) begin
      m_score = (m_score + 2 > 99) ? 99 : m_score + 2;
      push_ev(jc, 1'b1, 1'b0);
    end else if ($countones(mask) == 1 && mask == want && typ == 0) begin
      lose_life();
      push_ev(jc, 1'b0, 1'b1);
    end else begin
      count_miss();
      m_score = (m_score > 0) ? m_score - 1 : 0;
      push_ev(jc, 1'b0, 1'b1);
    end
  endtask

  task automatic model_timeout(input int typ, input int jc);
    if (m_over) return;
    if (typ == 1 || typ == 2) begin
      count_miss();
      lose_life();
      push_ev(jc, 1'b0, 1'b1);
    end
  endtask

  // Monitor: every DUT pulse must match the oldest expected judgement
  always @(negedge clk) begin : mon
    exp_t e;
    if (restart_n && (hit_pulse || miss_pulse)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b at cycle %0d expected none",
                 hit_pulse, miss_pulse, cyc);
      end else begin
        e = sbq.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("hit_pulse", int'(hit_pulse), int'(e.hit));
        check("miss_pulse", int'(miss_pulse), int'(e.miss));
        check("score_bcd", int'(score_bcd), to_bcd(e.score));
        check("lives", int'(lives), e.lives);
        check("misses", int'(misses), e.misses);
        check("game_over", int'(game_over), int'(e.over));
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_score"}, int'(score_bcd), to_bcd(m_score));
    check({tag, "_lives"}, int'(lives), m_lives);
    check({tag, "_misses"}, int'(misses), m_misses);
    check({tag, "_over"}, int'(game_over), int'(m_over));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sbq.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_event: got %0d pending judgements expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    restart_n = 1'b0;
    btn = 4'd0;
    new_mole = 1'b0;
    repeat (3) @(negedge clk);
    restart_n = 1'b1;
    model_reset();
  endtask

  // Presents a mole for one cycle; on return the mole has just been latched
  task automatic issue_mole(input int pos, input int typ);
    @(negedge clk);
    new_mole = 1'b1;
    anode    = ~(4'(1 << pos));
    mtype    = 3'(typ);
    @(negedge clk);
    new_mole = 1'b0;
  endtask

  task automatic txn_press(input int pos, input int typ, input logic [3:0] mask);
    issue_mole(pos, typ);
    btn = mask;
    model_press(pos, typ, mask, cyc + DB + 3);
    repeat (10) @(negedge clk);
    btn = 4'd0;
    repeat (DB + 4) @(negedge clk);
    drain();
  endtask

  task automatic txn_timeout(input int pos, input int typ);
    issue_mole(pos, typ);
    model_timeout(typ, cyc + W);
    repeat (W + 3) @(negedge clk);
    drain();
  endtask

  task automatic hit_until(input int target);
    int p;
    while (m_score < target) begin
      p = $urandom_range(0, 3);
      txn_press(p, 1, 4'(1 << p));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e;
    int a;
    int p;
    int t;
    logic [3:0] mk;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_score", int'(score_bcd), 8'h00);
    check("rst_lives", int'(lives), L);
    check("rst_misses", int'(misses), 0);
    check("rst_hit", int'(hit_pulse), 0);
    check("rst_miss", int'(miss_pulse), 0);
    check("rst_over", int'(game_over), 0);
    restart_n = 1'b1;
    @(negedge clk);

    // Glitch shorter than the debounce period, then a two-button press
    issue_mole(0, 1);
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    check_state("glitch");
    btn = 4'b0101;
    model_press(0, 1, 4'b0101, cyc + DB + 3);
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (DB + 4) @(negedge clk);
    drain();

    // Normal hit on digit 1, then a press while locked
    txn_press(1, 1, 4'b0010);
    btn = 4'b0010;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (DB + 4) @(negedge clk);
    check_state("locked_press");

    // BCD carry with a golden mole, then saturation at 99
    hit_until(9);
    txn_press(3, 2, 4'b1000);
    hit_until(98);
    txn_press(2, 2, 4'b0100);
    txn_press(0, 1, 4'b0001);

    // Plague hit costs a life only
    txn_press(2, 0, 4'b0100);

    // new_mole coincident with a press: the press is discarded
    do_reset();
    issue_mole(3, 1);
    btn = 4'b1000;
    repeat (DB + 2) @(negedge clk);
    new_mole = 1'b1;
    anode    = 4'b1110;
    mtype    = 3'd1;
    @(negedge clk);
    new_mole = 1'b0;
    model_timeout(1, cyc + W);
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    repeat (W) @(negedge clk);
    drain();

    // Press judged on the same edge the window expires
    issue_mole(2, 2);
    repeat (W - DB - 3) @(negedge clk);
    btn = 4'b0100;
    model_press(2, 2, 4'b0100, cyc + DB + 3);
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (DB + 4) @(negedge clk);
    drain();

    // Asynchronous reset in the middle of an armed window
    hit_until(5);
    issue_mole(1, 1);
    repeat (3) @(negedge clk);
    check_state("pre_async");
    #2;
    restart_n = 1'b0;
    #1;
    check("async_score", int'(score_bcd), 8'h00);
    check("async_lives", int'(lives), L);
    check("async_misses", int'(misses), 0);
    check("async_over", int'(game_over), 0);
    @(negedge clk);
    restart_n = 1'b1;
    model_reset();

    // Three unhit normal moles end the game; later presses are ignored
    for (int i = 0; i < 3; i++) txn_timeout($urandom_range(0, 3), 1);
    txn_press(0, 1, 4'b0001);
    check_state("after_over");

    // Randomized play
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (m_over) do_reset();
      p = $urandom_range(0, 3);
      t = $urandom_range(0, 7);
      e = $urandom_range(0, 9);
      if (e < 3) begin
        txn_timeout(p, t);
      end else begin
        if ($urandom_range(0, 9) < 7) mk = 4'(1 << p);
        else                          mk = 4'($urandom_range(1, 15));
        txn_press(p, t, mk);
      end
    end
    check_state("final");

    a = sbq.size();
    check("queue_empty", a, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
